// File: rtl/ram_fifo_ctrl.sv
// Stream FIFO backed by a ring buffer in external burst memory.
// Words are staged into the memory write FIFO, committed with a write burst, then read back in bursts.
module ram_fifo_ctrl #(
    parameter int unsigned Nb          = 16,
    parameter int unsigned Nb_addr     = 23,
    parameter int unsigned Nb_bl       = 6,
    parameter int unsigned Nb_inst     = 3,
    parameter int unsigned INSTR_WRITE = 0,
    parameter int unsigned INSTR_READ  = 1,
    parameter int unsigned BURST       = 16,
    parameter int unsigned RING_LOG2   = 16,
    parameter int unsigned BASE_ADDR   = 0
) (
    input  logic                 clk_core,
    input  logic                 reset,
    input  logic [Nb-1:0]        in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [Nb-1:0]        out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 flush,
    output logic                 flush_busy,
    output logic                 flush_done,
    output logic [RING_LOG2:0]   level,
    output logic [Nb_bl-1:0]     cmd_bl,
    output logic [Nb_inst-1:0]   cmd_instr,
    output logic [Nb_addr-1:0]   cmd_addr,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [Nb-1:0]        wr_data,
    output logic                 wr_valid,
    input  logic                 wr_ready,
    input  logic [Nb-1:0]        rd_data,
    input  logic                 rd_valid,
    output logic                 rd_ready
);

    localparam int unsigned RING_WORDS = 1 << RING_LOG2;

    typedef logic [RING_LOG2:0]   cnt_t;
    typedef logic [RING_LOG2-1:0] ptr_t;

    localparam cnt_t RingCnt  = cnt_t'(RING_WORDS);
    localparam cnt_t BurstCnt = cnt_t'(BURST);

    typedef enum logic [1:0] {StIdle, StWrCmd, StRdCmd} state_e;

    state_e             state_q, state_d;
    cnt_t               staged_q, staged_d;
    cnt_t               committed_q, committed_d;
    cnt_t               rd_pending_q, rd_pending_d;
    ptr_t               wr_ptr_q, wr_ptr_d;
    ptr_t               rd_ptr_q, rd_ptr_d;
    cnt_t               cmd_len_q, cmd_len_d;
    logic               flush_busy_q, flush_busy_d;
    logic               flush_done_q, flush_done_d;
    logic [Nb_bl-1:0]   cmd_bl_q, cmd_bl_d;
    logic [Nb_inst-1:0] cmd_instr_q, cmd_instr_d;
    logic [Nb_addr-1:0] cmd_addr_q, cmd_addr_d;

    cnt_t wr_room, wl, rd_room, rd_lim, rl, level_c;
    logic write_go, read_go, in_xfer, out_xfer, wr_accept, rd_accept;

    always_comb begin
        wr_room = RingCnt - {1'b0, wr_ptr_q};
        wl      = (wr_room < BurstCnt) ? wr_room : BurstCnt;
        rd_room = RingCnt - {1'b0, rd_ptr_q};
        rd_lim  = (rd_room < BurstCnt) ? rd_room : BurstCnt;
        rl      = (committed_q < rd_lim) ? committed_q : rd_lim;
        level_c = staged_q + committed_q + rd_pending_q;

        write_go = (staged_q == wl) || (flush_busy_q && staged_q != '0);
        read_go  = (rd_pending_q == '0) && (committed_q != '0) &&
                   ((committed_q >= rd_lim) || flush_busy_q);

        // No new staging during a flush so the drain terminates.
        in_ready  = !reset && (state_q == StIdle) && wr_ready && (staged_q < wl) &&
                    (level_c < RingCnt) && !flush_busy_q;
        wr_valid  = in_valid && in_ready;
        out_valid = !reset && rd_valid && (rd_pending_q != '0);
        rd_ready  = !reset && out_ready && (rd_pending_q != '0);
        in_xfer   = wr_valid;
        out_xfer  = out_valid && out_ready;
        wr_accept = (state_q == StWrCmd) && cmd_ready;
        rd_accept = (state_q == StRdCmd) && cmd_ready;
    end

    assign wr_data    = in_data;
    assign out_data   = rd_data;
    assign level      = level_c;
    assign cmd_valid  = (state_q != StIdle);
    assign cmd_bl     = cmd_bl_q;
    assign cmd_instr  = cmd_instr_q;
    assign cmd_addr   = cmd_addr_q;
    assign flush_busy = flush_busy_q;
    assign flush_done = flush_done_q;

    always_comb begin
        state_d     = state_q;
        cmd_len_d   = cmd_len_q;
        cmd_bl_d    = cmd_bl_q;
        cmd_instr_d = cmd_instr_q;
        cmd_addr_d  = cmd_addr_q;
        case (state_q)
            StIdle: begin
                if (write_go) begin
                    state_d     = StWrCmd;
                    cmd_len_d   = staged_q;
                    cmd_bl_d    = Nb_bl'(staged_q - cnt_t'(1));
                    cmd_instr_d = Nb_inst'(INSTR_WRITE);
                    cmd_addr_d  = Nb_addr'(BASE_ADDR) + Nb_addr'(wr_ptr_q);
                end else if (read_go) begin
                    state_d     = StRdCmd;
                    cmd_len_d   = rl;
                    cmd_bl_d    = Nb_bl'(rl - cnt_t'(1));
                    cmd_instr_d = Nb_inst'(INSTR_READ);
                    cmd_addr_d  = Nb_addr'(BASE_ADDR) + Nb_addr'(rd_ptr_q);
                end
            end
            StWrCmd, StRdCmd: begin
                if (cmd_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Stream transfers and command acceptance may coincide; all deltas apply together.
    always_comb begin
        staged_d     = staged_q + (in_xfer ? cnt_t'(1) : '0) - (wr_accept ? cmd_len_q : '0);
        committed_d  = committed_q + (wr_accept ? cmd_len_q : '0) - (rd_accept ? cmd_len_q : '0);
        rd_pending_d = rd_pending_q - (out_xfer ? cnt_t'(1) : '0) + (rd_accept ? cmd_len_q : '0);
        wr_ptr_d     = wr_accept ? wr_ptr_q + cmd_len_q[RING_LOG2-1:0] : wr_ptr_q;
        rd_ptr_d     = rd_accept ? rd_ptr_q + cmd_len_q[RING_LOG2-1:0] : rd_ptr_q;
        flush_busy_d = flush_busy_q ? (level_c != '0) : flush;
        flush_done_d = flush_busy_q && (level_c == '0);
    end

    always_ff @(posedge clk_core) begin
        if (reset) begin
            state_q      <= StIdle;
            staged_q     <= '0;
            committed_q  <= '0;
            rd_pending_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cmd_len_q    <= '0;
            flush_busy_q <= 1'b0;
            flush_done_q <= 1'b0;
            cmd_bl_q     <= '0;
            cmd_instr_q  <= '0;
            cmd_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            staged_q     <= staged_d;
            committed_q  <= committed_d;
            rd_pending_q <= rd_pending_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cmd_len_q    <= cmd_len_d;
            flush_busy_q <= flush_busy_d;
            flush_done_q <= flush_done_d;
            cmd_bl_q     <= cmd_bl_d;
            cmd_instr_q  <= cmd_instr_d;
            cmd_addr_q   <= cmd_addr_d;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl on a 64-word ring, with a behavioural burst-memory model.
module tb_ram_fifo_ctrl;

    localparam int unsigned Nb = 16, Nb_addr = 23, Nb_bl = 6, Nb_inst = 3;
    localparam int unsigned RingLog2 = 6, Ring = 64;

    logic                 clk_core = 1'b0;
    logic                 reset;
    logic [Nb-1:0]        in_data;
    logic                 in_valid, in_ready;
    logic [Nb-1:0]        out_data;
    logic                 out_valid, out_ready;
    logic                 flush, flush_busy, flush_done;
    logic [RingLog2:0]    level;
    logic [Nb_bl-1:0]     cmd_bl;
    logic [Nb_inst-1:0]   cmd_instr;
    logic [Nb_addr-1:0]   cmd_addr;
    logic                 cmd_valid, cmd_ready;
    logic [Nb-1:0]        wr_data;
    logic                 wr_valid, wr_ready;
    logic [Nb-1:0]        rd_data = '0;
    logic                 rd_valid = 1'b0;
    logic                 rd_ready;

    always #5 clk_core = ~clk_core;

    ram_fifo_ctrl #(
        .Nb(Nb), .Nb_addr(Nb_addr), .Nb_bl(Nb_bl), .Nb_inst(Nb_inst),
        .INSTR_WRITE(0), .INSTR_READ(1), .BURST(16), .RING_LOG2(RingLog2), .BASE_ADDR(0)
    ) dut (
        .clk_core(clk_core), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .flush(flush), .flush_busy(flush_busy), .flush_done(flush_done), .level(level),
        .cmd_bl(cmd_bl), .cmd_instr(cmd_instr), .cmd_addr(cmd_addr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready)
    );

    int total = 0, bad = 0;
    logic [Nb-1:0] mem [Ring];
    logic [Nb-1:0] wq[$], rq[$], out_log[$];
    logic [31:0]   cmd_log[$];
    int n_in = 0, done_cnt = 0, model_err = 0, straddle = 0, seq_err = 0;
    bit wrap_seen = 0, wr_seen = 0, rand_rdy = 0;
    logic [5:0] exp_wr = '0, exp_rd = '0;

    // Memory model and monitor: sample at the clock edge, drive read data with <=.
    initial begin
        forever begin
            @(posedge clk_core);
            if (reset) begin
                wq.delete();
                rq.delete();
                exp_wr = '0;
                exp_rd = '0;
                wr_seen = 0;
                rd_valid <= 1'b0;
                rd_data <= '0;
            end else begin
                if (wr_valid && wr_ready) wq.push_back(wr_data);
                if (in_valid && in_ready) n_in++;
                if (out_valid && out_ready) out_log.push_back(out_data);
                if (rd_valid && rd_ready && rq.size() > 0) void'(rq.pop_front());
                if (flush_done) done_cnt++;
                if (cmd_valid && cmd_ready) begin
                    cmd_log.push_back({cmd_instr, cmd_addr, cmd_bl});
                    if (int'(cmd_addr) + int'(cmd_bl) >= Ring) straddle++;
                    if (cmd_instr == 3'd0) begin
                        if (cmd_addr[5:0] != exp_wr) seq_err++;
                        if (wr_seen && cmd_addr == '0) wrap_seen = 1;
                        for (int i = 0; i <= int'(cmd_bl); i++) begin
                            logic [5:0] idx;
                            idx = cmd_addr[5:0] + 6'(i);
                            if (wq.size() > 0) mem[idx] = wq.pop_front();
                            else model_err++;
                        end
                        exp_wr = 6'(cmd_addr[5:0] + cmd_bl + 6'd1);
                        wr_seen = 1;
                    end else begin
                        if (cmd_addr[5:0] != exp_rd) seq_err++;
                        for (int i = 0; i <= int'(cmd_bl); i++) begin
                            logic [5:0] idx;
                            idx = cmd_addr[5:0] + 6'(i);
                            rq.push_back(mem[idx]);
                        end
                        exp_rd = 6'(cmd_addr[5:0] + cmd_bl + 6'd1);
                    end
                end
                rd_valid <= (rq.size() > 0);
                rd_data  <= (rq.size() > 0) ? rq[0] : '0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] mk(input int instr, input int addr, input int bl);
        return {3'(instr), 23'(addr), 6'(bl)};
    endfunction

    task automatic chk_cmd(input string tag, input int idx, input logic [31:0] expv);
        if (idx < cmd_log.size()) chk(tag, cmd_log[idx], expv);
        else chk({tag, "_count"}, cmd_log.size(), idx + 1);
    endtask

    task automatic tick();
        @(posedge clk_core);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push(input int n, input int first, input int max_cyc);
        int base = n_in;
        int c = 0;
        while (n_in - base < n && c < max_cyc) begin
            in_valid = 1'b1;
            in_data  = 16'(first + n_in - base);
            tick();
            c++;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_level0(input string tag, input int max_cyc);
        int c = 0;
        while (level != '0 && c < max_cyc) begin
            tick();
            c++;
        end
        chk(tag, level, 0);
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int d0 = done_cnt;
        int c = 0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk({tag, "_busy_set"}, flush_busy, 1);
        while (done_cnt == d0 && c < max_cyc) begin
            tick();
            c++;
        end
        repeat (3) tick();
        chk({tag, "_done_pulses"}, done_cnt - d0, 1);
        chk({tag, "_busy_clr"}, flush_busy, 0);
        chk({tag, "_level"}, level, 0);
    endtask

    task automatic check_stream(input string tag, input int first, input int n);
        int err = 0;
        chk({tag, "_len"}, out_log.size(), n);
        for (int i = 0; i < n && i < out_log.size(); i++)
            if (out_log[i] !== 16'(first + i)) err++;
        chk({tag, "_data"}, err, 0);
        out_log.delete();
    endtask

    initial begin
        int base, err, c;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; flush = 1'b0;
        cmd_ready = 1'b1; wr_ready = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_flush_busy", flush_busy, 0);
        chk("rst_rd_ready", rd_ready, 0);
        reset = 1'b0;
        tick();
        chk("idle_in_ready", in_ready, 1);

        // Full burst round trip
        cmd_log.delete();
        push(16, 1, 100);
        wait_level0("t30_level", 200);
        chk("t30_ncmd", cmd_log.size(), 2);
        chk_cmd("t30_wr", 0, mk(0, 0, 15));
        chk_cmd("t30_rd", 1, mk(1, 0, 15));
        check_stream("t30", 1, 16);

        // Partial burst drained by flush
        cmd_log.delete();
        push(5, 'h100, 50);
        repeat (3) tick();
        chk("t31_nocmd", cmd_log.size(), 0);
        drain("t31", 200);
        chk_cmd("t31_wr", 0, mk(0, 16, 4));
        chk_cmd("t31_rd", 1, mk(1, 16, 4));
        check_stream("t31", 'h100, 5);

        // Command stall keeps fields stable and blocks staging
        cmd_log.delete();
        cmd_ready = 1'b0;
        base = n_in;
        push(16, 'h200, 100);
        tick();
        in_valid = 1'b1;
        in_data = 16'h02ff;
        err = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!(cmd_valid && cmd_addr == 23'd21 && cmd_bl == 6'd15 && cmd_instr == 3'd0 &&
                  !in_ready)) err++;
        end
        chk("t34_stable", err, 0);
        chk("t34_accepted", n_in - base, 16);
        chk("t34_nocmd", cmd_log.size(), 0);
        in_valid = 1'b0;
        cmd_ready = 1'b1;
        wait_level0("t34_level", 200);
        chk_cmd("t34_wr", 0, mk(0, 21, 15));
        chk_cmd("t34_rd", 1, mk(1, 21, 15));
        check_stream("t34", 'h200, 16);

        // Ring full with blocked output
        cmd_log.delete();
        out_ready = 1'b0;
        base = n_in;
        push(70, 'h1000, 300);
        chk("t32_accepted", n_in - base, 64);
        chk("t32_level_full", level, 64);
        chk("t32_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        push(6, 'h1040, 300);
        chk("t32_accepted_all", n_in - base, 70);
        drain("t32", 500);
        check_stream("t32", 'h1000, 70);

        // Long run with random backpressure across several ring wraps
        cmd_log.delete();
        wrap_seen = 0;
        rand_rdy = 1;
        push(200, 'h2000, 3000);
        drain("t33", 2000);
        rand_rdy = 0;
        out_ready = 1'b1;
        check_stream("t33", 'h2000, 200);
        chk("t33_straddle", straddle, 0);
        chk("t33_addr_seq", seq_err, 0);
        chk("t33_wrap", wrap_seen, 1);
        chk("t33_model", model_err, 0);

        // Reset in the middle of a read burst
        out_ready = 1'b0;
        push(16, 'h3000, 100);
        c = 0;
        while (!out_valid && c < 100) begin
            tick();
            c++;
        end
        chk("t35_out_valid", out_valid, 1);
        out_ready = 1'b1;
        repeat (2) tick();
        in_valid = 1'b1;
        reset = 1'b1;
        tick();
        chk("t35_cmd_valid", cmd_valid, 0);
        chk("t35_level", level, 0);
        chk("t35_in_ready", in_ready, 0);
        chk("t35_wr_valid", wr_valid, 0);
        chk("t35_out_valid0", out_valid, 0);
        chk("t35_rd_ready", rd_ready, 0);
        chk("t35_cmd_fields", {cmd_instr, cmd_addr, cmd_bl}, 0);
        chk("t35_flush_busy", flush_busy, 0);
        in_valid = 1'b0;
        reset = 1'b0;
        tick();
        out_log.delete();
        cmd_log.delete();
        push(16, 1, 100);
        wait_level0("t35b_level", 200);
        chk_cmd("t35b_wr", 0, mk(0, 0, 15));
        chk_cmd("t35b_rd", 1, mk(1, 0, 15));
        check_stream("t35b", 1, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
